// File: rtl/output_pkg.sv
// ---------------------------------------------------------------------------
// output_pkg
// Shared definitions for the output-register arbiter:
//   state_t        FSM encoding (IDLE / WRITE / HOLD)
//   REQ_CPU/DBG    requester IDs used for grants and last_grant
//   DEFAULT_WIDTH  default data width of requests and the output register
// ---------------------------------------------------------------------------
package output_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin grant. The priority register itself
// lives in the parent; this block only decides who wins this cycle.
// Ports:
//   valid0, valid1  request lines of requester 0 (CPU) and 1 (debug)
//   rr_prio         requester that wins when both are valid
//   grant_valid     at least one request is pending
//   grant_id        ID of the winning requester (meaningful with grant_valid)
// ---------------------------------------------------------------------------
module rr_arbiter2
  import output_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic rr_prio,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = valid0 | valid1;

  always_comb begin
    grant_id = REQ_CPU;
    if (valid0 && valid1) begin
      grant_id = rr_prio;
    end else if (valid1) begin
      grant_id = REQ_DBG;
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// ---------------------------------------------------------------------------
// output_port_arbiter
// Shares the output register between the CPU store path (requester 0) and
// the debug/monitor path (requester 1). An accepted request produces a
// one-cycle write pulse with the captured data, then the value is held for
// HOLD_CYCLES cycles so the display can show it before the next grant.
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   req0_valid/data/ready   CPU request, data, one-cycle acknowledge
//   req1_valid/data/ready   debug request, data, one-cycle acknowledge
//   out_data, out_write     output register data_in and outputWrite pulse
//   busy                    high whenever the FSM is not IDLE
//   last_grant              ID of the most recently granted requester
//   write_count             completed writes, wrapping at 2^CNT_W
// All outputs are registered.
// ---------------------------------------------------------------------------
module output_port_arbiter
  import output_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_write,
  output logic             busy,
  output logic             last_grant,
  output logic [CNT_W-1:0] write_count
);

  // The hold counter only needs to hold HOLD_CYCLES-1.
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_INIT =
    (HOLD_CYCLES > 0) ? HC_W'(HOLD_CYCLES - 1) : '0;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             out_write_reg, out_write_next;
  logic             ready0_reg, ready0_next;
  logic             ready1_reg, ready1_next;
  logic             busy_reg, busy_next;
  logic             last_grant_reg, last_grant_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             rr_prio_reg, rr_prio_next;
  logic [HC_W-1:0]  hold_reg, hold_next;

  logic grant_valid;
  logic grant_id;

  rr_arbiter2 u_rr_arbiter2 (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .rr_prio     (rr_prio_reg),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_next      = state_reg;
    out_data_next   = out_data_reg;
    out_write_next  = 1'b0;
    ready0_next     = 1'b0;
    ready1_next     = 1'b0;
    last_grant_next = last_grant_reg;
    count_next      = count_reg;
    rr_prio_next    = rr_prio_reg;
    hold_next       = hold_reg;

    case (state_reg)
      IDLE: begin
        // Requests are only looked at here; WRITE and HOLD ignore them.
        if (grant_valid) begin
          out_data_next   = (grant_id == REQ_DBG) ? req1_data : req0_data;
          out_write_next  = 1'b1;
          ready0_next     = (grant_id == REQ_CPU);
          ready1_next     = (grant_id == REQ_DBG);
          last_grant_next = grant_id;
          rr_prio_next    = ~grant_id;
          count_next      = count_reg + CNT_W'(1);
          state_next      = WRITE;
        end
      end
      WRITE: begin
        if (HOLD_CYCLES == 0) begin
          state_next = IDLE;
        end else begin
          state_next = HOLD;
          hold_next  = HOLD_INIT;
        end
      end
      HOLD: begin
        if (hold_reg == '0) begin
          state_next = IDLE;
        end else begin
          hold_next = hold_reg - HC_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      out_data_reg   <= '0;
      out_write_reg  <= 1'b0;
      ready0_reg     <= 1'b0;
      ready1_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      last_grant_reg <= REQ_CPU;
      count_reg      <= '0;
      rr_prio_reg    <= REQ_CPU;
      hold_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      out_data_reg   <= out_data_next;
      out_write_reg  <= out_write_next;
      ready0_reg     <= ready0_next;
      ready1_reg     <= ready1_next;
      busy_reg       <= busy_next;
      last_grant_reg <= last_grant_next;
      count_reg      <= count_next;
      rr_prio_reg    <= rr_prio_next;
      hold_reg       <= hold_next;
    end
  end

  assign out_data    = out_data_reg;
  assign out_write   = out_write_reg;
  assign req0_ready  = ready0_reg;
  assign req1_ready  = ready1_reg;
  assign busy        = busy_reg;
  assign last_grant  = last_grant_reg;
  assign write_count = count_reg;

endmodule
